// File: rtl/pll_dyncfg_ctrl.sv
// pll_dyncfg_ctrl: runtime reconfiguration master for the EG_PHY_PLL
// dynamic-configuration port. Each request holds the PLL in reset, writes
// REFCLK_DIV, FBCLK_DIV and CLKC0_DIV (as div-1), releases reset and waits
// for a filtered, stable extlock.
// Optional feature: define PLL_DYNCFG_VERIFY_EN to read every divider
// register back before releasing reset.
module pll_dyncfg_ctrl #(
  parameter int         RST_CYCLES   = 4,
  parameter int         LOCK_STABLE  = 16,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter int         DRP_RD_LAT   = 2,
  parameter logic [5:0] ADDR_REFDIV  = 6'h00,
  parameter logic [5:0] ADDR_FBDIV   = 6'h01,
  parameter logic [5:0] ADDR_C0DIV   = 6'h02
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] refclk_div,
  input  logic [7:0] fbclk_div,
  input  logic [7:0] clkc0_div,
  output logic       done,
  output logic [1:0] err,
  output logic       locked,
  output logic       pll_reset,
  input  logic       extlock,
  output logic       drp_cs,
  output logic       drp_we,
  output logic [5:0] drp_addr,
  output logic [7:0] drp_di,
  input  logic [7:0] drp_do
);

  localparam int SW = (LOCK_STABLE < 1) ? 1 : $clog2(LOCK_STABLE + 1);

`ifdef PLL_DYNCFG_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_RST, S_WRITE, S_VERIFY, S_RELEASE, S_WAIT, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RST, S_WRITE, S_RELEASE, S_WAIT, S_DONE} state_t;
  // drp_do is only consumed by the read-back path
  logic unused_do;
  assign unused_do = ^{drp_do, DRP_RD_LAT[0]};
`endif

  state_t          state_reg, state_next;
  logic [2:0][7:0] div_reg;
  logic [15:0]     cnt_reg, cnt_next;
  logic [1:0]      idx_reg, idx_next;
  logic [1:0]      err_reg, err_next;
  logic            prst_reg, prst_next;
  logic [15:0]     tmo_reg, tmo_next;
  logic            accept;
  logic            lock_clr;
  logic            ext_s1_reg, ext_s2_reg;
  logic [SW-1:0]   stab_reg;
  logic            locked_reg;
  logic            lock_next;
  logic [5:0]      cur_addr;
  logic [7:0]      cur_val;

  // Address and encoded value (div-1) of the register currently addressed
  always_comb begin
    cur_addr = ADDR_C0DIV;
    cur_val  = div_reg[2] - 8'd1;
    case (idx_reg)
      2'd0:    begin cur_addr = ADDR_REFDIV; cur_val = div_reg[0] - 8'd1; end
      2'd1:    begin cur_addr = ADDR_FBDIV;  cur_val = div_reg[1] - 8'd1; end
      default: begin cur_addr = ADDR_C0DIV;  cur_val = div_reg[2] - 8'd1; end
    endcase
  end

  // Two-flop synchronizer for the PLL lock output
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ext_s1_reg <= 1'b0;
      ext_s2_reg <= 1'b0;
    end else begin
      ext_s1_reg <= extlock;
      ext_s2_reg <= ext_s1_reg;
    end
  end

  // Lock filter: rises after LOCK_STABLE high samples, drops on the first low
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stab_reg   <= '0;
      locked_reg <= 1'b0;
    end else if (lock_clr || !ext_s2_reg) begin
      stab_reg   <= '0;
      locked_reg <= 1'b0;
    end else if (!locked_reg) begin
      stab_reg   <= stab_reg + 1'b1;
      locked_reg <= (stab_reg == SW'(LOCK_STABLE - 1));
    end
  end

  // Value locked will take at the next edge; lets done coincide with locked
  assign lock_next = ext_s2_reg && !lock_clr &&
                     (locked_reg || (stab_reg == SW'(LOCK_STABLE - 1)));

  // Sequencer state and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
      div_reg   <= '0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      err_reg   <= 2'b00;
      prst_reg  <= 1'b0;
      tmo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) div_reg <= {clkc0_div, fbclk_div, refclk_div};
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      err_reg   <= err_next;
      prst_reg  <= prst_next;
      tmo_reg   <= tmo_next;
    end
  end

  // Next-state logic and DRP strobe decode
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    err_next   = err_reg;
    prst_next  = prst_reg;
    tmo_next   = tmo_reg;
    accept     = 1'b0;
    lock_clr   = 1'b0;
    req_ready  = 1'b0;
    done       = 1'b0;
    drp_cs     = 1'b0;
    drp_we     = 1'b0;
    drp_addr   = '0;
    drp_di     = '0;
    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          err_next = 2'b00;
          cnt_next = '0;
          idx_next = '0;
          if (refclk_div == 8'd0 || fbclk_div == 8'd0 || clkc0_div == 8'd0) begin
            err_next   = 2'b01;
            state_next = S_DONE;
          end else begin
            prst_next  = 1'b1;
            state_next = S_RST;
          end
        end
      end
      S_RST: begin
        if (cnt_reg == 16'(RST_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = S_WRITE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      S_WRITE: begin
        if (cnt_reg == 16'd0) begin
          // strobe cycle
          drp_cs   = 1'b1;
          drp_we   = 1'b1;
          drp_addr = cur_addr;
          drp_di   = cur_val;
          cnt_next = 16'd1;
        end else begin
          // gap cycle; advance to the next register
          cnt_next = '0;
          if (idx_reg == 2'd2) begin
            idx_next = '0;
`ifdef PLL_DYNCFG_VERIFY_EN
            state_next = S_VERIFY;
`else
            prst_next  = 1'b0;
            state_next = S_RELEASE;
`endif
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end
      end
`ifdef PLL_DYNCFG_VERIFY_EN
      S_VERIFY: begin
        if (cnt_reg == 16'd0) begin
          drp_cs   = 1'b1;
          drp_addr = cur_addr;
        end
        if (cnt_reg == 16'(DRP_RD_LAT)) begin
          cnt_next = '0;
          if (drp_do != cur_val) begin
            // PLL deliberately left in reset
            err_next   = 2'b10;
            state_next = S_DONE;
          end else if (idx_reg == 2'd2) begin
            idx_next   = '0;
            prst_next  = 1'b0;
            state_next = S_RELEASE;
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
`endif
      S_RELEASE: begin
        // tmo counts cycles elapsed since this release cycle
        lock_clr   = 1'b1;
        tmo_next   = 16'd1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (lock_next) begin
          err_next   = 2'b00;
          state_next = S_DONE;
        end else if (tmo_reg == 16'(LOCK_TIMEOUT - 1)) begin
          err_next   = 2'b11;
          state_next = S_DONE;
        end else begin
          tmo_next = tmo_reg + 16'd1;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign err       = err_reg;
  assign pll_reset = prst_reg;
  assign locked    = locked_reg;

endmodule

// File: tb/tb_pll_dyncfg_ctrl.sv
// tb_pll_dyncfg_ctrl: directed and randomized requests against a
// cycle-timeline reference model; follows PLL_DYNCFG_VERIFY_EN like the DUT.
module tb_pll_dyncfg_ctrl;
  localparam int RC = 4;
  localparam int LS = 16;
  localparam int LT = 100;
  localparam int LAT = 2;
`ifdef PLL_DYNCFG_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif
  localparam int VX = VER * 3 * (1 + LAT);
  localparam int REL = RC + 7 + VX;   // release cycle offset from accept
  localparam int MAXC = 20000;

  logic clk = 0, resetn = 0, req_valid = 0, extlock = 0;
  logic [7:0] refclk_div = 0, fbclk_div = 0, clkc0_div = 0, drp_do = 0;
  logic req_ready, done, locked, pll_reset, drp_cs, drp_we;
  logic [1:0] err;
  logic [5:0] drp_addr;
  logic [7:0] drp_di;

  always #5 clk = ~clk;

  pll_dyncfg_ctrl #(.LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .refclk_div(refclk_div), .fbclk_div(fbclk_div), .clkc0_div(clkc0_div),
    .done(done), .err(err), .locked(locked), .pll_reset(pll_reset),
    .extlock(extlock), .drp_cs(drp_cs), .drp_we(drp_we), .drp_addr(drp_addr),
    .drp_di(drp_di), .drp_do(drp_do));

  int total = 0, bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (timeline of one request) -------------
  bit ext_hist [MAXC];
  bit m_busy = 0, m_bad = 0, m_fail = 0, m_prst = 0;
  int m_T = 0, m_R = -1, m_done = -1, clr_c = 0;
  logic [1:0] m_err = 0, m_pend = 0;
  logic [7:0] m_div [3];
  bit fault_fb = 0;
  bit e_ready = 1, e_done = 0, e_prst = 0, e_locked = 0, e_cs = 0, e_we = 0;
  int e_addr = 0, e_di = 0;

  function automatic bit lock_model(input int c);
    if (c - LS <= clr_c) return 0;
    for (int k = c - LS; k <= c - 1; k++) begin
      if (k - 2 < 0 || k - 2 >= MAXC) return 0;
      if (!ext_hist[k - 2]) return 0;
    end
    return 1;
  endfunction

  always @(posedge clk) begin
    bit acc;
    if (cyc < MAXC) ext_hist[cyc] = extlock;
    acc = resetn && e_ready && req_valid;
    cyc++;
    if (!resetn) begin
      m_busy = 0; m_prst = 0; m_err = 0; m_R = -1; m_done = -1; clr_c = cyc + 1;
    end else begin
      if (acc) begin
        m_T = cyc - 1; m_busy = 1; m_R = -1; m_done = -1; m_fail = 0;
        m_div[0] = refclk_div; m_div[1] = fbclk_div; m_div[2] = clkc0_div;
        m_bad = (refclk_div == 0 || fbclk_div == 0 || clkc0_div == 0);
        if (m_bad) begin
          m_done = cyc; m_pend = 2'b01;
        end else begin
          m_prst = 1;
          if (VER == 1 && fault_fb && (fbclk_div - 8'd1) != 8'h0F) begin
            m_fail = 1; m_pend = 2'b10;
            m_done = m_T + RC + 7 + (1 + LAT) + LAT + 1;
          end else begin
            m_R = m_T + REL;
          end
        end
      end
      if (m_busy && m_R >= 0 && m_done < 0 && cyc >= m_R + 2) begin
        if (lock_model(cyc)) begin m_done = cyc; m_pend = 2'b00; end
        else if (cyc == m_R + LT) begin m_done = cyc; m_pend = 2'b11; end
      end
      if (m_busy && cyc == m_done) m_err = m_pend;
      if (m_busy && m_R >= 0 && cyc == m_R) m_prst = 0;
      if (m_busy && m_done >= 0 && cyc > m_done) m_busy = 0;
    end
    // expected outputs for the cycle that just began
    e_ready = !m_busy; e_done = m_busy && cyc == m_done; e_prst = m_prst;
    e_locked = lock_model(cyc);
    e_cs = 0; e_we = 0; e_addr = 0; e_di = 0;
    if (m_busy && !m_bad) begin
      for (int i = 0; i < 3; i++) begin
        if (cyc - m_T == RC + 1 + 2 * i) begin
          logic [7:0] v;
          v = m_div[i] - 8'd1;
          e_cs = 1; e_we = 1; e_addr = i; e_di = v;
        end
        if (VER == 1 && (i <= 1 || !m_fail) && cyc - m_T == RC + 7 + (1 + LAT) * i) begin
          e_cs = 1; e_we = 0; e_addr = i;
        end
      end
    end
    if (m_busy && m_R >= 0 && cyc == m_R) clr_c = m_R;
  end

  // ---------------- per-cycle compare -----------------------------------
  always @(negedge clk) begin
    if (!resetn) begin
      chk("reset_outputs", {req_ready, done, err, locked, pll_reset, drp_cs, drp_we, drp_addr, drp_di},
          22'h200000);
    end else begin
      chk("req_ready", req_ready, e_ready);
      chk("done", done, e_done);
      chk("pll_reset", pll_reset, e_prst);
      chk("locked", locked, e_locked);
      chk("drp_cs", drp_cs, e_cs);
      chk("drp_we", drp_we, e_cs && e_we);
      if (e_cs) chk("drp_addr", drp_addr, e_addr);
      if (e_cs && e_we) chk("drp_di", drp_di, e_di);
      if (e_done || e_ready) chk("err", err, m_err);
    end
  end

  // ---------------- DRP slave and observation monitor --------------------
  bit [7:0] regf [64];
  int ws_q[$];
  int cs_cnt = 0, prst_rise = 0, prst_fall = -1, last_done = -1, locked_seen = 0;
  logic [1:0] last_err = 0;
  logic prev_prst = 0;

  always @(negedge clk) begin
    if (drp_cs && drp_we) regf[drp_addr] = drp_di;
    else if (drp_cs) drp_do = (fault_fb && drp_addr == 6'h01) ? 8'h0F : regf[drp_addr];
    if (drp_cs) cs_cnt++;
    if (drp_cs && drp_we) ws_q.push_back(cyc);
    if (!prev_prst && pll_reset) prst_rise++;
    if (prev_prst && !pll_reset && resetn) prst_fall = cyc;
    if (locked) locked_seen++;
    if (done) begin last_done = cyc; last_err = err; end
    prev_prst = pll_reset;
  end

  // ---------------- extlock driver ----------------------------------------
  int lock_at = -1, glitch_at = -1;
  always @(posedge clk) begin
    #1;
    extlock = (lock_at >= 0 && cyc >= lock_at && cyc != glitch_at);
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, output int t);
    int n;
    @(posedge clk); #1;
    n = 0;
    while (!e_ready && n < 1000) begin @(posedge clk); #1; n++; end
    if (!e_ready) chk("ready_bound", e_ready, 1);
    ws_q.delete(); cs_cnt = 0; prst_rise = 0; prst_fall = -1; last_done = -1; locked_seen = 0;
    req_valid = 1; refclk_div = a; fbclk_div = b; clkc0_div = c;
    t = cyc; lock_at = -1; glitch_at = -1;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_done(input bit noise);
    for (int i = 0; i < 600 && m_busy; i++) begin
      @(posedge clk); #1;
      if (noise && !e_ready) begin
        req_valid = 1'($urandom_range(0, 1));
        refclk_div = 8'($urandom); fbclk_div = 8'($urandom); clkc0_div = 8'($urandom);
      end else req_valid = 0;
    end
    req_valid = 0;
    if (m_busy) chk("done_bound", m_busy, 0);
    $display("txn T=%0d done_at=%0d err=%0d locked_cycles=%0d", m_T, last_done, last_err, locked_seen);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, L;
    resetn = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    repeat (2) @(posedge clk);

    // basic write and lock
    issue(8'd24, 8'd16, 8'd30, t);
    L = t + REL + 5; lock_at = L;
    wait_done(0);
    chk("ws_count", ws_q.size(), 3);
    if (ws_q.size() == 3) begin
      chk("ws0_off", ws_q[0] - t, 5);
      chk("ws1_off", ws_q[1] - t, 7);
      chk("ws2_off", ws_q[2] - t, 9);
    end
    chk("reg00", regf[0], 23);
    chk("reg01", regf[1], 15);
    chk("reg02", regf[2], 29);
    chk("prst_fall_off", prst_fall - t, 11 + VX);
    chk("lock_done_off", last_done - L, 18);
    chk("basic_err", last_err, 0);

    // bad argument
    issue(8'd10, 8'd0, 8'd20, t);
    wait_done(0);
    chk("bad_done_off", last_done - t, 1);
    chk("bad_err", last_err, 1);
    chk("bad_cs_cnt", cs_cnt, 0);
    chk("bad_prst_rise", prst_rise, 0);

    // lock timeout
    issue(8'd5, 8'd6, 8'd7, t);
    wait_done(0);
    chk("tmo_done_off", last_done - t, REL + LT);
    chk("tmo_err", last_err, 3);
    chk("tmo_locked", locked_seen, 0);

    // lock glitch restarts the filter
    issue(8'd33, 8'd44, 8'd55, t);
    L = t + REL + 5; lock_at = L; glitch_at = L + 8;
    wait_done(0);
    chk("glitch_done_off", last_done - L, 27);
    chk("glitch_err", last_err, 0);

`ifdef PLL_DYNCFG_VERIFY_EN
    // read-back mismatch on address 01
    fault_fb = 1;
    issue(8'd24, 8'd20, 8'd30, t);
    wait_done(0);
    chk("vfy_done_off", last_done - t, 17);
    chk("vfy_err", last_err, 2);
    chk("vfy_prst_held", pll_reset, 1);
    fault_fb = 0;
    issue(8'd24, 8'd16, 8'd30, t);
    lock_at = t + REL + 3;
    wait_done(0);
    chk("vfy_ok_err", last_err, 0);
    chk("vfy_prst_fall", prst_fall - t, 20);
`endif

    // reset between the first and second write strobes
    regf[0] = 0;
    issue(8'd24, 8'd16, 8'd30, t);
    repeat (5) @(posedge clk);
    #1 resetn = 0;
    @(negedge clk);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_prst", pll_reset, 0);
    chk("midrst_ws", ws_q.size(), 1);
    chk("midrst_reg00", regf[0], 23);
    @(posedge clk); @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    chk("after_rst_ready", req_ready, 1);
    $display("txn T=%0d reset mid-write", t);

    // randomized requests with random lock behaviour and ignored strobes
    for (int n = 0; n < 20; n++) begin
      logic [7:0] a, b, c;
      int mode;
      a = 8'($urandom_range(1, 255)); b = 8'($urandom_range(1, 255)); c = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: a = 0;
          1: b = 0;
          default: c = 0;
        endcase
      end
      fault_fb = (VER == 1) && ($urandom_range(0, 2) == 0);
      mode = $urandom_range(0, 3);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(a, b, c, t);
      if (mode != 0) begin
        lock_at = t + REL + $urandom_range(0, 30);
        if ($urandom_range(0, 1) == 1) glitch_at = lock_at + $urandom_range(0, 20);
      end
      wait_done(1);
    end
    fault_fb = 0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
